// File: rtl/alu_op_sequencer.sv
// Registered command/result wrapper around the 4-bit combinational arithmetic unit.
// Adds valid/ready handshakes on both sides, plus a sticky overflow flag and a saturating overflow counter.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_q,
    input  logic             alu_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic             res_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] res_q_q, res_q_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_valid_q, res_valid_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             capture_c;
    logic             qual_ovf_c;
    logic [CNT_W-1:0] cnt_base_c;

    // Logic ops never report overflow, whatever the unit drives on alu_ovf.
    assign qual_ovf_c = alu_ovf & ~alu_sel_q[1];

    // Handshake FSM and datapath next-state.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_q_d     = res_q_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;
        capture_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                capture_c   = 1'b1;
                res_q_d     = alu_q;
                res_ovf_d   = qual_ovf_c;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Clear is applied before a coincident overflow event, so clear+event leaves a count of one.
    always_comb begin
        cnt_base_c = ovf_clr ? '0 : cnt_q;
        sticky_d   = ovf_clr ? 1'b0 : sticky_q;
        cnt_d      = cnt_base_c;
        if (capture_c && qual_ovf_c) begin
            sticky_d = 1'b1;
            if (cnt_base_c != CNT_MAX) begin
                cnt_d = cnt_base_c + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_q_q     <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_q_q     <= res_q_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    // Ready is gated by rst so it drops the moment reset asserts.
    assign cmd_ready  = (state_q == IDLE) & ~rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign res_q      = res_q_q;
    assign res_ovf    = res_ovf_q;
    assign res_valid  = res_valid_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural model of the 4-bit arithmetic unit.
module tb_alu_op_sequencer;

    localparam int unsigned W    = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_sel;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [W-1:0]  alu_a, alu_b, alu_q;
    logic [1:0]    alu_sel;
    logic          alu_ovf, m_ovf, force_ovf;
    logic          res_valid, res_ready, res_ovf;
    logic [W-1:0]  res_q;
    logic          ovf_sticky, ovf_clr;
    logic [CW-1:0] ovf_count;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W:0]    sb_q[$];
    int            exp_cnt = 0;
    logic          exp_sticky = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_q(alu_q), .alu_ovf(alu_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_ovf(res_ovf),
        .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
    );

    // Reference arithmetic unit: returns {overflow, q}; overflow is signed add/sub overflow.
    function automatic logic [W:0] unit_model(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic         o;
        o = 1'b0;
        case (s)
            2'b00: begin q = a + b; o = (a[W-1] == b[W-1]) && (q[W-1] != a[W-1]); end
            2'b01: begin q = a - b; o = (a[W-1] != b[W-1]) && (q[W-1] != a[W-1]); end
            2'b10: q = a | b;
            default: q = a & b;
        endcase
        return {o, q};
    endfunction

    assign {m_ovf, alu_q} = unit_model(alu_sel, alu_a, alu_b);
    assign alu_ovf = m_ovf | force_ovf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic frc, input int stall, input logic clr_cap);
        logic [W:0] r;
        logic [W:0] got;
        logic       e_ovf;
        @(negedge clk);
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        force_ovf = frc;
        res_ready = (stall == 0);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        r     = unit_model(s, a, b);
        e_ovf = (r[W] | frc) & ~s[1];
        sb_q.push_back({e_ovf, r[W-1:0]});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ovf_clr   = clr_cap;
        @(negedge clk);
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("alu_a_reg", 32'(alu_a), 32'(a));
        check("alu_b_reg", 32'(alu_b), 32'(b));
        check("alu_sel_reg", 32'(alu_sel), 32'(s));
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        if (clr_cap) begin
            exp_cnt    = 0;
            exp_sticky = 1'b0;
        end
        if (e_ovf) begin
            exp_sticky = 1'b1;
            if (exp_cnt < CMAX) exp_cnt++;
        end
        @(negedge clk);
        force_ovf = 1'b0;
        check("hold_res_valid", 32'(res_valid), 32'd1);
        check("sb_size", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            got = {res_ovf, res_q};
            r   = sb_q.pop_front();
            check("res_q", 32'(got[W-1:0]), 32'(r[W-1:0]));
            check("res_ovf", 32'(got[W]), 32'(r[W]));
        end
        check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
        check("ovf_count", 32'(ovf_count), 32'(exp_cnt));
        got = {res_ovf, res_q};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res", 32'({res_ovf, res_q}), 32'(got));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("post_res_valid", 32'(res_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b0; ovf_clr = 1'b0; force_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        rst = 1'b0;

        run_op(2'b00, 4'b0011, 4'b0100, 1'b0, 0, 1'b0);   // 3+4 = 7
        run_op(2'b00, 4'b0101, 4'b0100, 1'b0, 0, 1'b0);   // 5+4 overflows

        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        @(negedge clk);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);
        check("clr_count", 32'(ovf_count), 32'd0);

        run_op(2'b10, 4'b0101, 4'b0011, 1'b1, 0, 1'b0);   // OR with forced overflow
        run_op(2'b11, 4'b1100, 4'b1010, 1'b1, 0, 1'b0);   // AND with forced overflow
        run_op(2'b01, 4'b1000, 4'b0001, 1'b0, 5, 1'b0);   // -8-1 under backpressure
        run_op(2'b01, 4'b0010, 4'b0101, 1'b0, 0, 1'b0);   // 2-5, no overflow

        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        for (int k = 0; k < 5; k++) run_op(2'b00, 4'b0101, 4'b0100, 1'b0, 0, 1'b0);
        run_op(2'b00, 4'b0110, 4'b0111, 1'b0, 0, 1'b1);   // clear coincides with capture

        // Reset during EXEC discards the in-flight op.
        @(negedge clk);
        cmd_sel = 2'b00; cmd_a = 4'b0001; cmd_b = 4'b0001; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0; exp_sticky = 1'b0;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        check("mid_rst_res", 32'({res_ovf, res_q}), 32'd0);
        check("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
        check("mid_rst_count", 32'(ovf_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | res_valid;
        end
        check("no_ghost_result", 32'(seen), 32'd0);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        run_op(2'b00, 4'b0010, 4'b0011, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
